// File: rtl/tc_d_drain.sv
// tc_d_drain: result-drain stage between the tensor_core D port and writeback.
// Buffers 512-bit result beats in a DEPTH-entry FIFO, counts beats per tile,
// marks the final beat with m_axis_tlast and pulses irq_o on tile completion.
// Optional feature macro: TC_DRAIN_STAT_EN adds the stat_tiles_o counter port.
module tc_d_drain #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [511:0]             s_axis_tdata_d,
    input  logic                     s_axis_tvalid_d,
    output logic                     s_axis_tready_d,
    output logic [511:0]             m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    input  logic                     en_i,
    input  logic [7:0]               cfg_beats,
    output logic                     busy_o,
    output logic                     irq_o,
`ifdef TC_DRAIN_STAT_EN
    output logic [15:0]              stat_tiles_o,
`endif
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [LW-1:0] lvl_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t       state_r;
    state_t       state_s;
    logic [511:0] mem_r [DEPTH];
    ptr_t         wr_ptr_r;
    ptr_t         rd_ptr_r;
    lvl_t         count_r;
    logic [7:0]   beats_r;
    logic [7:0]   in_cnt_r;
    logic [7:0]   out_cnt_r;

    logic         full_s;
    logic         push_s;
    logic         pop_s;
    logic         clear_s;
    logic         last_in_s;
    logic         last_out_s;

    // Handshake and control decode, all derived from registered state
    always_comb begin
        full_s     = (count_r == lvl_t'(DEPTH));
        push_s     = s_axis_tvalid_d && s_axis_tready_d;
        pop_s      = m_axis_tvalid && m_axis_tready;
        clear_s    = ((state_r == ST_RUN) || (state_r == ST_FLUSH)) && !en_i;
        last_in_s  = (in_cnt_r == (beats_r - 8'd1));
        last_out_s = (out_cnt_r == (beats_r - 8'd1));
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; dropping en_i aborts the tile from RUN or FLUSH
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (en_i) state_s = ST_RUN;
                else      state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (!en_i)                     state_s = ST_IDLE;
                else if (push_s && last_in_s)  state_s = ST_FLUSH;
                else                           state_s = ST_RUN;
            end
            ST_FLUSH: begin
                if (!en_i)                          state_s = ST_IDLE;
                else if (count_r == {LW{1'b0}})     state_s = ST_DONE;
                else                                state_s = ST_FLUSH;
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM and FIFO status outputs
    always_comb begin
        s_axis_tready_d = (state_r == ST_RUN) && !full_s;
        busy_o          = (state_r != ST_IDLE);
        irq_o           = (state_r == ST_DONE);
        m_axis_tvalid   = (count_r != {LW{1'b0}});
        m_axis_tlast    = m_axis_tvalid && last_out_s;
        m_axis_tdata    = mem_r[rd_ptr_r];
        level_o         = count_r;
    end

    // FIFO storage; contents need no reset since occupancy gates visibility
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= s_axis_tdata_d;
        end
    end

    // FIFO pointers and occupancy; an abort empties the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {LW{1'b0}};
        end else if (clear_s) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {LW{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + ptr_t'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + ptr_t'(1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + lvl_t'(1);
                2'b01:   count_r <= count_r - lvl_t'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Tile length latch, captured only when a tile starts (0 means 1 beat)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beats_r <= 8'd1;
        end else if ((state_r == ST_IDLE) && en_i) begin
            beats_r <= (cfg_beats == 8'd0) ? 8'd1 : cfg_beats;
        end
    end

    // Input and output beat counters, held at zero while idle or aborting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt_r  <= 8'd0;
            out_cnt_r <= 8'd0;
        end else if ((state_r == ST_IDLE) || clear_s) begin
            in_cnt_r  <= 8'd0;
            out_cnt_r <= 8'd0;
        end else begin
            if (push_s) begin
                in_cnt_r <= last_in_s ? 8'd0 : (in_cnt_r + 8'd1);
            end
            if (pop_s) begin
                out_cnt_r <= last_out_s ? 8'd0 : (out_cnt_r + 8'd1);
            end
        end
    end

`ifdef TC_DRAIN_STAT_EN
    // Completed-tile statistic; wraps naturally and survives aborts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_tiles_o <= 16'd0;
        end else if (state_r == ST_DONE) begin
            stat_tiles_o <= stat_tiles_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tc_d_drain.sv
// Self-checking bench for tc_d_drain: randomized tiles checked against a
// queue-based model of the drain (beats in = beats out, in order, tlast on
// the N-th output, irq two cycles after the final output), plus directed
// abort and mid-tile reset sequences.
module tb_tc_d_drain;

    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic           clk;
    logic           rst_n;
    logic [511:0]   s_axis_tdata_d;
    logic           s_axis_tvalid_d;
    logic           s_axis_tready_d;
    logic [511:0]   m_axis_tdata;
    logic           m_axis_tvalid;
    logic           m_axis_tready;
    logic           m_axis_tlast;
    logic           en_i;
    logic [7:0]     cfg_beats;
    logic           busy_o;
    logic           irq_o;
    logic [LW-1:0]  level_o;
`ifdef TC_DRAIN_STAT_EN
    logic [15:0]    stat_tiles_o;
`endif

    int total_cnt = 0;
    int pass_cnt  = 0;
    int tiles_done = 0;

    tc_d_drain #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s_axis_tdata_d  (s_axis_tdata_d),
        .s_axis_tvalid_d (s_axis_tvalid_d),
        .s_axis_tready_d (s_axis_tready_d),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .m_axis_tlast    (m_axis_tlast),
        .en_i            (en_i),
        .cfg_beats       (cfg_beats),
        .busy_o          (busy_o),
        .irq_o           (irq_o),
`ifdef TC_DRAIN_STAT_EN
        .stat_tiles_o    (stat_tiles_o),
`endif
        .level_o         (level_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // One full tile: n beats in, the same n beats out in order, tlast on the
    // last, irq two cycles after the final output transfer.
    task automatic run_tile(input int cfg, input int vpct, input int rpct, input int hold);
        int           n;
        int           acc;
        int           got;
        int           since;
        int           cyc;
        bit           done;
        bit           stall_prev;
        logic [511:0] stall_d;
        logic         stall_l;
        logic [511:0] cur;
        logic [511:0] q[$];
        n = (cfg == 0) ? 1 : cfg;
        acc = 0; got = 0; since = -1; cyc = 0; done = 1'b0; stall_prev = 1'b0;
        stall_d = '0; stall_l = 1'b0;
        cur = rand512();
        en_i = 1'b1;
        cfg_beats = 8'(cfg);
        s_axis_tvalid_d = 1'b0;
        m_axis_tready = 1'b0;
        @(posedge clk); #1;
        cfg_beats = 8'($urandom);
        while (!done && cyc < 400) begin
            s_axis_tvalid_d = (acc < n) && ($urandom_range(0, 99) < vpct);
            s_axis_tdata_d  = cur;
            m_axis_tready   = (cyc >= hold) && ($urandom_range(0, 99) < rpct);
            @(negedge clk);
            if (since >= 0) since++;
            check("level", level_o, q.size());
            check("m_tvalid", m_axis_tvalid, q.size() != 0);
            check("s_tready", s_axis_tready_d, (acc < n) && (q.size() < DEPTH));
            check("irq", irq_o, since == 2);
            check("busy", busy_o, 1'b1);
            if (hold > 0 && cyc == hold - 1)
                check("fill_acc", acc, (n < DEPTH) ? n : DEPTH);
            if (m_axis_tvalid && q.size() != 0) begin
                check("m_tdata", m_axis_tdata, q[0]);
                check("m_tlast", m_axis_tlast, got == n - 1);
                if (stall_prev) begin
                    check("stall_data", m_axis_tdata, stall_d);
                    check("stall_last", m_axis_tlast, stall_l);
                end
                if (m_axis_tready) begin
                    void'(q.pop_front());
                    got++;
                    if (got == n) since = 0;
                end
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            stall_d = m_axis_tdata;
            stall_l = m_axis_tlast;
            if (s_axis_tvalid_d && s_axis_tready_d) begin
                q.push_back(cur);
                acc++;
                cur = rand512();
            end
            if (since == 2) done = 1'b1;
            cyc++;
            @(posedge clk); #1;
        end
        if (!done) check("tile_timeout", 1'b0, 1'b1);
        tiles_done++;
        en_i = 1'b0;
        s_axis_tvalid_d = 1'b0;
        m_axis_tready = 1'b0;
        @(negedge clk);
        check("busy_after", busy_o, 1'b0);
        check("irq_after", irq_o, 1'b0);
    endtask

    logic [511:0] d0;

    initial begin
        rst_n = 1'b0;
        en_i = 1'b0;
        cfg_beats = 8'd0;
        s_axis_tdata_d = '0;
        s_axis_tvalid_d = 1'b0;
        m_axis_tready = 1'b0;
        d0 = '0;
        #1;
        check("rst_s_tready", s_axis_tready_d, 1'b0);
        check("rst_m_tvalid", m_axis_tvalid, 1'b0);
        check("rst_tlast", m_axis_tlast, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_irq", irq_o, 1'b0);
        check("rst_level", level_o, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back 4-beat tile, writeback always ready
        run_tile(4, 100, 100, 0);
        // 8-beat tile with writeback stalled: FIFO fills to DEPTH, then drains
        run_tile(8, 100, 100, 12);
        // cfg_beats = 0 behaves as a single-beat tile
        run_tile(0, 100, 100, 0);

        // Abort: 3 of 6 beats accepted, one delivered, then en_i dropped
        en_i = 1'b1;
        cfg_beats = 8'd6;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            s_axis_tdata_d = rand512();
            if (i == 0) d0 = s_axis_tdata_d;
            s_axis_tvalid_d = 1'b1;
            @(negedge clk);
            check("abort_s_tready", s_axis_tready_d, 1'b1);
            @(posedge clk); #1;
        end
        s_axis_tvalid_d = 1'b0;
        @(negedge clk);
        check("abort_level3", level_o, 3);
        check("abort_data0", m_axis_tdata, d0);
        check("abort_tlast0", m_axis_tlast, 1'b0);
        m_axis_tready = 1'b1;
        @(posedge clk); #1;
        m_axis_tready = 1'b0;
        @(negedge clk);
        check("abort_level2", level_o, 2);
        check("abort_tlast1", m_axis_tlast, 1'b0);
        en_i = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", busy_o, 1'b0);
        check("abort_level0", level_o, 0);
        check("abort_m_tvalid", m_axis_tvalid, 1'b0);
        check("abort_irq", irq_o, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_irq_later", irq_o, 1'b0);
        end
        // Counters must restart from zero after the abort
        run_tile(3, 90, 90, 0);

        // Reset mid-tile with two beats buffered
        en_i = 1'b1;
        cfg_beats = 8'd6;
        @(posedge clk); #1;
        s_axis_tvalid_d = 1'b1;
        s_axis_tdata_d = rand512();
        @(posedge clk); #1;
        s_axis_tdata_d = rand512();
        @(posedge clk); #1;
        s_axis_tvalid_d = 1'b0;
        @(negedge clk);
        check("rstmid_level2", level_o, 2);
        rst_n = 1'b0;
        en_i = 1'b0;
        #1;
        check("rstmid_level", level_o, 0);
        check("rstmid_m_tvalid", m_axis_tvalid, 1'b0);
        check("rstmid_s_tready", s_axis_tready_d, 1'b0);
        check("rstmid_busy", busy_o, 1'b0);
        check("rstmid_tlast", m_axis_tlast, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rstmid_irq_after", irq_o, 1'b0);
            check("rstmid_busy_after", busy_o, 1'b0);
        end

        // Stalled writeback with random readiness
        run_tile(5, 70, 50, 0);
        for (int t = 0; t < 3; t++) run_tile(2, 80, 40, 0);
        for (int t = 0; t < 4; t++) run_tile($urandom_range(1, 20), 75, 60, 0);

`ifdef TC_DRAIN_STAT_EN
        check("stat_tiles", stat_tiles_o, tiles_done);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/tc_d_drain.md
TC_D_DRAIN -- requirements
Module: tc_d_drain

Interface
REQ-001 Parameter DEPTH, default 4, result FIFO depth in 512-bit beats, power of two, 2..16.
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 s_axis_tdata_d  input  512  result beat from tensor_core D port.
REQ-005 s_axis_tvalid_d  input  1  result beat valid.
REQ-006 s_axis_tready_d  output  1  drain accepts beat.
REQ-007 m_axis_tdata  output  512  beat to writeback.
REQ-008 m_axis_tvalid  output  1  output beat valid.
REQ-009 m_axis_tready  input  1  writeback accepts beat.
REQ-010 m_axis_tlast  output  1  marks final beat of tile.
REQ-011 en_i  input  1  start tile drain; low aborts.
REQ-012 cfg_beats  input  8  beats per tile; 0 treated as 1.
REQ-013 busy_o  output  1  high outside IDLE.
REQ-014 irq_o  output  1  one-cycle tile-complete pulse.
REQ-015 level_o  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-016 FSM states IDLE, RUN, FLUSH, DONE; a beat transfers on any port only when valid and ready are both high in the same cycle.
REQ-017 IDLE->RUN when en_i=1; cfg_beats latched that cycle; later cfg_beats changes ignored until next IDLE.
REQ-018 s_axis_tready_d = (state==RUN) && FIFO not full; combinational from registered state and occupancy only.
REQ-019 Accepted input beat appears on m_axis_tdata with m_axis_tvalid=1 no earlier than the next cycle (1-cycle minimum latency); order preserved.
REQ-020 m_axis_tvalid = FIFO not empty; m_axis_tdata/m_axis_tlast held stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-021 Input beat counter increments per accepted input; on acceptance of beat number latched_beats-1, RUN->FLUSH and s_axis_tready_d deasserts from the next cycle.
REQ-022 m_axis_tlast=1 only on the output beat whose output count equals latched_beats-1; output counter resets to 0 on that transfer.
REQ-023 FLUSH->DONE when FIFO empty; DONE: irq_o=1 for exactly one cycle, then ->IDLE.
REQ-024 Simultaneous push and pop: occupancy unchanged; when full, no push that cycle even if pop occurs.
REQ-025 en_i=0 in RUN or FLUSH: next cycle ->IDLE, FIFO and counters cleared, no irq_o, no tlast emitted.
REQ-026 busy_o=1 in RUN, FLUSH, DONE; 0 in IDLE.
REQ-027 en_i held high after DONE starts a new tile on the cycle after returning to IDLE.

Reset
REQ-028 rst_n low asynchronously forces IDLE, occupancy 0, counters 0, s_axis_tready_d=0, m_axis_tvalid=0, m_axis_tlast=0, busy_o=0, irq_o=0, level_o=0; m_axis_tdata contents don't-care.
REQ-029 Reset assertion mid-tile discards all buffered beats; no irq_o on reset release.

Configuration
REQ-030 Macro TC_DRAIN_STAT_EN defined: adds output stat_tiles_o (16 bits), count of completed tiles (incremented in DONE), wrapping 0xFFFF->0, reset to 0, not cleared by abort.
REQ-031 Macro undefined: port and counter absent; all other behaviour identical.

Verification
REQ-032 cfg_beats=4, en_i=1, 4 back-to-back beats 0x1..0x4, m_axis_tready=1 -> outputs 0x1..0x4 in order, tlast only on 0x4, irq_o one pulse after last output, busy_o back to 0.
REQ-033 DEPTH=4, cfg_beats=8, m_axis_tready=0 -> exactly 4 beats accepted, s_axis_tready_d=0, level_o=4; release ready -> all 8 delivered, no loss.
REQ-034 cfg_beats=0 -> single beat accepted with tlast=1 and irq_o pulse.
REQ-035 cfg_beats=6, en_i dropped after 3 accepted beats -> IDLE next cycle, level_o=0, no irq_o, no tlast.
REQ-036 rst_n pulsed low mid-tile with level_o=2 -> all outputs at reset values immediately, no irq_o after release.
REQ-037 TC_DRAIN_STAT_EN defined, 3 tiles of cfg_beats=2 -> stat_tiles_o=3; random m_axis_tready stalls -> data stable while stalled.
